// File: rtl/whack_scorer.sv
// Whack-a-mole scorer: detects pad presses, classifies hits/wrong presses/escapes,
// and keeps saturating two-digit BCD score and miss counters until game over.
module whack_scorer #(
    parameter int unsigned MAX_MISSES = 5
) (
    input  logic        clock_14MHz_i,
    input  logic        reset_i,
    input  logic        tick_i,
    input  logic [15:0] mole_i,
    input  logic [15:0] button_i,
    output logic        whacked_o,
    output logic        hit_pulse_o,
    output logic [7:0]  score_o,
    output logic [7:0]  misses_o,
    output logic        game_over_o
);

    localparam int unsigned NUM_PADS = 16;
    localparam int unsigned BCD_W    = 8;
    localparam logic [BCD_W-1:0] MAX_BCD = {4'(MAX_MISSES / 10), 4'(MAX_MISSES % 10)};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_WHACKED,
        S_LOCKED,
        S_OVER
    } state_t;

    state_t              state;
    state_t              nxt_state;
    state_t              period_state;
    logic [NUM_PADS-1:0] button_q;
    logic                primed_q;
    logic [NUM_PADS-1:0] press_c;
    logic                hit_c;
    logic                wrong_c;
    logic                hit_evt;
    logic                miss_evt;
    logic [BCD_W-1:0]    nxt_score;
    logic [BCD_W-1:0]    nxt_misses;

    // Two-digit BCD increment that sticks at 99.
    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
        if (v == 8'h99)
            return v;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // primed_q masks the first cycle after reset so a held pad is not a press.
    always_comb begin
        press_c      = button_i & ~button_q & {NUM_PADS{primed_q}};
        hit_c        = |(press_c & mole_i);
        wrong_c      = (|press_c) && !hit_c;
        period_state = (|mole_i) ? S_ARMED : S_IDLE;
        nxt_state    = state;
        hit_evt      = 1'b0;
        miss_evt     = 1'b0;

        case (state)
            S_IDLE: begin
                if (wrong_c) begin
                    miss_evt  = 1'b1;
                    nxt_state = S_LOCKED;
                end else begin
                    nxt_state = period_state;
                end
            end
            S_ARMED: begin
                if (hit_c) begin
                    hit_evt   = 1'b1;
                    nxt_state = tick_i ? period_state : S_WHACKED;
                end else if (wrong_c) begin
                    miss_evt  = 1'b1;
                    nxt_state = tick_i ? period_state : S_LOCKED;
                end else if (tick_i) begin
                    miss_evt  = 1'b1;
                    nxt_state = period_state;
                end else begin
                    nxt_state = period_state;
                end
            end
            S_WHACKED, S_LOCKED: begin
                if (tick_i)
                    nxt_state = period_state;
            end
            S_OVER: nxt_state = S_OVER;
            default: nxt_state = S_IDLE;
        endcase

        nxt_score  = hit_evt  ? bcd_inc(score_o)  : score_o;
        nxt_misses = miss_evt ? bcd_inc(misses_o) : misses_o;
        if (miss_evt && (nxt_misses == MAX_BCD))
            nxt_state = S_OVER;
    end

    always_ff @(posedge clock_14MHz_i) begin
        if (reset_i) begin
            state       <= S_IDLE;
            score_o     <= 8'h00;
            misses_o    <= 8'h00;
            whacked_o   <= 1'b0;
            hit_pulse_o <= 1'b0;
            game_over_o <= 1'b0;
            button_q    <= 16'h0000;
            primed_q    <= 1'b0;
        end else begin
            state       <= nxt_state;
            score_o     <= nxt_score;
            misses_o    <= nxt_misses;
            whacked_o   <= (nxt_state == S_WHACKED);
            hit_pulse_o <= hit_evt;
            game_over_o <= (nxt_state == S_OVER);
            button_q    <= button_i;
            primed_q    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_whack_scorer.sv
// Scoreboard bench for whack_scorer: each driven cycle queues its expected outputs,
// which are popped and compared just after the clock edge.
module tb_whack_scorer;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic [15:0] mole;
    logic [15:0] btn;
    logic        whacked;
    logic        hit_pulse;
    logic [7:0]  score;
    logic [7:0]  misses;
    logic        game_over;

    int    n_tests = 0;
    int    n_fail  = 0;
    string phase   = "init";

    typedef struct {
        string tag;
        int    sc;
        int    ms;
        int    wh;
        int    hp;
        int    go;
    } exp_t;

    exp_t exp_q[$];

    whack_scorer #(.MAX_MISSES(5)) dut (
        .clock_14MHz_i (clk),
        .reset_i       (rst),
        .tick_i        (tick),
        .mole_i        (mole),
        .button_i      (btn),
        .whacked_o     (whacked),
        .hit_pulse_o   (hit_pulse),
        .score_o       (score),
        .misses_o      (misses),
        .game_over_o   (game_over)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Drive one cycle, queue its expectation, then compare after the edge (-1 skips a field).
    task automatic cyc(input logic t, input logic [15:0] m, input logic [15:0] b,
                       input int sc, input int ms, input int wh, input int hp, input int go);
        exp_t e;
        tick = t;
        mole = m;
        btn  = b;
        e.tag = phase; e.sc = sc; e.ms = ms; e.wh = wh; e.hp = hp; e.go = go;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (e.sc >= 0) check({e.tag, "/score"},   score,             to_bcd(e.sc));
        if (e.ms >= 0) check({e.tag, "/misses"},  misses,            to_bcd(e.ms));
        if (e.wh >= 0) check({e.tag, "/whacked"}, {7'd0, whacked},   8'(e.wh));
        if (e.hp >= 0) check({e.tag, "/hit"},     {7'd0, hit_pulse}, 8'(e.hp));
        if (e.go >= 0) check({e.tag, "/over"},    {7'd0, game_over}, 8'(e.go));
    endtask

    task automatic do_reset(input logic [15:0] m, input logic [15:0] b);
        rst = 1'b1;
        cyc(1'b0, m, b, 0, 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; mole = '0; btn = '0;
        phase = "reset";
        do_reset(16'h0000, 16'h0000);
        cyc(0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);

        phase = "hit";
        cyc(1, 16'h0010, 16'h0000, 0, 0, 0, 0, 0);
        cyc(0, 16'h0010, 16'h0010, 1, 0, 1, 1, 0);
        cyc(0, 16'h0010, 16'h0010, 1, 0, 1, 0, 0);
        cyc(0, 16'h0010, 16'h0000, 1, 0, 1, 0, 0);
        cyc(1, 16'h0000, 16'h0000, 1, 0, 0, 0, 0);

        phase = "wrong_lock";
        cyc(0, 16'h0010, 16'h0000, 1, 0, 0, 0, 0);
        cyc(0, 16'h0010, 16'h0008, 1, 1, 0, 0, 0);
        cyc(0, 16'h0010, 16'h0000, 1, 1, 0, 0, 0);
        cyc(0, 16'h0010, 16'h0010, 1, 1, 0, 0, 0);
        cyc(1, 16'h0010, 16'h0000, 1, 1, 0, 0, 0);
        cyc(0, 16'h0010, 16'h0010, 2, 1, 1, 1, 0);
        cyc(1, 16'h0000, 16'h0000, 2, 1, 0, 0, 0);

        phase = "hit_tick";
        cyc(0, 16'h0001, 16'h0000, 2, 1, 0, 0, 0);
        cyc(1, 16'h0001, 16'h0001, 3, 1, 0, 1, 0);
        cyc(0, 16'h0001, 16'h0000, 3, 1, 0, 0, 0);

        phase = "wrong_tick";
        cyc(1, 16'h0001, 16'h0002, 3, 2, 0, 0, 0);
        cyc(0, 16'h0001, 16'h0000, 3, 2, 0, 0, 0);
        cyc(0, 16'h0001, 16'h0001, 4, 2, 1, 1, 0);
        cyc(1, 16'h0000, 16'h0000, 4, 2, 0, 0, 0);

        phase = "hit_wins";
        cyc(0, 16'h0100, 16'h0000, 4, 2, 0, 0, 0);
        cyc(0, 16'h0100, 16'h0101, 5, 2, 1, 1, 0);
        cyc(1, 16'h0000, 16'h0000, 5, 2, 0, 0, 0);

        phase = "idle_wrong";
        cyc(0, 16'h0000, 16'h0004, 5, 3, 0, 0, 0);
        cyc(0, 16'h0020, 16'h0000, 5, 3, 0, 0, 0);
        cyc(0, 16'h0020, 16'h0020, 5, 3, 0, 0, 0);
        cyc(1, 16'h0020, 16'h0000, 5, 3, 0, 0, 0);
        cyc(0, 16'h0020, 16'h0020, 6, 3, 1, 1, 0);
        cyc(1, 16'h0000, 16'h0000, 6, 3, 0, 0, 0);

        phase = "reset_mid";
        cyc(0, 16'h0040, 16'h0000, 6, 3, 0, 0, 0);
        cyc(0, 16'h0040, 16'h0040, 7, 3, 1, 1, 0);
        do_reset(16'h0040, 16'h0040);
        cyc(0, 16'h0040, 16'h0040, 0, 0, 0, 0, 0);
        cyc(0, 16'h0040, 16'h0040, 0, 0, 0, 0, 0);
        cyc(0, 16'h0040, 16'h0000, 0, 0, 0, 0, 0);
        cyc(0, 16'h0040, 16'h0040, 1, 0, 1, 1, 0);

        phase = "bcd_sat";
        do_reset(16'h0000, 16'h0000);
        for (int i = 1; i <= 100; i++) begin
            cyc(1, 16'h0001, 16'h0000, (i - 1 > 99) ? 99 : i - 1, 0, 0, 0, 0);
            cyc(0, 16'h0001, 16'h0001, (i > 99) ? 99 : i, 0, 1, (i > 99) ? -1 : 1, 0);
        end

        phase = "game_over";
        do_reset(16'h0000, 16'h0000);
        cyc(1, 16'h0002, 16'h0000, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++)
            cyc(1, 16'h0002, 16'h0000, 0, k, 0, 0, (k == 5) ? 1 : 0);
        cyc(0, 16'h0002, 16'h0002, 0, 5, 0, 0, 1);
        cyc(1, 16'h0002, 16'h0000, 0, 5, 0, 0, 1);
        cyc(0, 16'h0000, 16'h0004, 0, 5, 0, 0, 1);
        cyc(1, 16'h0000, 16'h0000, 0, 5, 0, 0, 1);

        phase = "reset_over";
        do_reset(16'h0000, 16'h0000);
        cyc(0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
